fifo_seq_ctrl: RTL and testbench

- Control-side sequencer for the partial-sum FIFO in the conv/maxpool datapath.
- Generates the FIFO strobes: rd_clr, wr_clr, rd_inc, wr_inc, rd_en, wr_en.
- Sequence: one fill pass, N-1 read-modify-write accumulation passes, one drain pass.
- Emits valid strobes aligned to the FIFO's 1-cycle read latency, so the downstream adder and output stage need no timing knowledge.

---
 rtl/fifo_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_fifo_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_seq_ctrl.sv
// fifo_seq_ctrl: control sequencer for the partial-sum FIFO in the conv/maxpool datapath.
//
// The sequence is one fill pass, num_pass-1 read-modify-write accumulation passes and one
// drain pass. Read-data valid strobes (acc_vld, out_vld) lag rd_en by one cycle to match
// the FIFO's 1-cycle read latency. All outputs are registered.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a sequence; only accepted in IDLE with a legal row_len
//   row_len           entries per pass (1..FIFO_SIZE), latched at start
//   num_pass          accumulation passes (0 behaves as 1), latched at start
//   stall             holds the sequencer at a pass boundary (GAP)
//   rd_clr, wr_clr    FIFO pointer clears
//   rd_en, rd_inc     FIFO read enable / read-pointer increment
//   wr_en, wr_inc     FIFO write enable / write-pointer increment
//   acc_vld           FIFO read data valid during accumulation
//   out_vld           FIFO read data valid during drain (final result)
//   first_pass        adder selects 0 instead of FIFO data (fill pass)
//   pass_idx          current pass number, 0-based, saturating
//   busy, done        sequence in progress / one-cycle completion pulse
//   err               (only with FIFO_SEQ_CTRL_ERR_EN) sticky flag for illegal or
//                     overlapping starts, cleared by reset or an accepted start
//
// Optional feature macro: FIFO_SEQ_CTRL_ERR_EN.

module fifo_seq_ctrl #(
  parameter int unsigned FIFO_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned PASS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] row_len,
  input  logic [PASS_WIDTH-1:0] num_pass,
  input  logic                  stall,
  output logic                  rd_clr,
  output logic                  wr_clr,
  output logic                  rd_en,
  output logic                  rd_inc,
  output logic                  wr_en,
  output logic                  wr_inc,
  output logic                  acc_vld,
  output logic                  out_vld,
  output logic                  first_pass,
  output logic [PASS_WIDTH-1:0] pass_idx,
  output logic                  busy,
`ifdef FIFO_SEQ_CTRL_ERR_EN
  output logic                  err,
`endif
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle, StClr, StFill, StGap, StAcc, StDrain, StDone
  } state_e;

  localparam logic [ADDR_WIDTH:0]   MaxLen  = (ADDR_WIDTH + 1)'(FIFO_SIZE);
  localparam logic [PASS_WIDTH-1:0] PassMax = '1;

  state_e                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] len;
  logic [PASS_WIDTH-1:0] npass;

  logic                  row_ok;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic [PASS_WIDTH-1:0] pass_nxt;

  assign row_ok   = (row_len != '0) && ({1'b0, row_len} <= MaxLen);
  assign cnt_nxt  = cnt + ADDR_WIDTH'(1);
  assign len_m1   = len - ADDR_WIDTH'(1);
  assign pass_nxt = (pass_idx == PassMax) ? pass_idx : pass_idx + PASS_WIDTH'(1);

  // Outputs are assigned for the state being entered, so they are valid in the same
  // cycle the state register shows that state. Pulse strobes default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      len        <= '0;
      npass      <= '0;
      rd_clr     <= 1'b0;
      wr_clr     <= 1'b0;
      rd_en      <= 1'b0;
      rd_inc     <= 1'b0;
      wr_en      <= 1'b0;
      wr_inc     <= 1'b0;
      acc_vld    <= 1'b0;
      out_vld    <= 1'b0;
      first_pass <= 1'b0;
      pass_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_clr     <= 1'b0;
      wr_clr     <= 1'b0;
      rd_en      <= 1'b0;
      rd_inc     <= 1'b0;
      wr_en      <= 1'b0;
      wr_inc     <= 1'b0;
      acc_vld    <= 1'b0;
      out_vld    <= 1'b0;
      first_pass <= 1'b0;
      done       <= 1'b0;

      case (state)
        StIdle: begin
          if (start && row_ok) begin
            len      <= row_len;
            npass    <= (num_pass == '0) ? PASS_WIDTH'(1) : num_pass;
            pass_idx <= '0;
            rd_clr   <= 1'b1;
            wr_clr   <= 1'b1;
            busy     <= 1'b1;
            state    <= StClr;
          end
        end

        StClr: begin
          cnt        <= '0;
          wr_en      <= 1'b1;
          wr_inc     <= 1'b1;
          first_pass <= 1'b1;
          state      <= StFill;
        end

        StFill: begin
          if (cnt == len_m1) begin
            rd_clr   <= 1'b1;
            wr_clr   <= 1'b1;
            pass_idx <= pass_nxt;
            state    <= StGap;
          end else begin
            cnt        <= cnt_nxt;
            wr_en      <= 1'b1;
            wr_inc     <= 1'b1;
            first_pass <= 1'b1;
          end
        end

        StGap: begin
          if (stall) begin
            rd_clr <= 1'b1;
            wr_clr <= 1'b1;
          end else begin
            // k=0 of the next pass: first read issued, nothing to write back yet.
            cnt    <= '0;
            rd_en  <= 1'b1;
            rd_inc <= 1'b1;
            state  <= (pass_idx < npass) ? StAcc : StDrain;
          end
        end

        StAcc: begin
          if (cnt == len) begin
            rd_clr   <= 1'b1;
            wr_clr   <= 1'b1;
            pass_idx <= pass_nxt;
            state    <= StGap;
          end else begin
            // Write back entry k-1 while reading entry k; indices never coincide.
            cnt     <= cnt_nxt;
            rd_en   <= (cnt_nxt != len);
            rd_inc  <= (cnt_nxt != len);
            wr_en   <= 1'b1;
            wr_inc  <= 1'b1;
            acc_vld <= 1'b1;
          end
        end

        StDrain: begin
          if (cnt == len) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            cnt     <= cnt_nxt;
            rd_en   <= (cnt_nxt != len);
            rd_inc  <= (cnt_nxt != len);
            out_vld <= 1'b1;
          end
        end

        StDone: begin
          busy     <= 1'b0;
          pass_idx <= '0;
          state    <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

`ifdef FIFO_SEQ_CTRL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start) begin
      if (state != StIdle || !row_ok) begin
        err <= 1'b1;
      end else begin
        err <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Bench for fifo_seq_ctrl: builds the expected per-cycle strobe trace from the sequence
// rules, drives randomized row_len/num_pass/stall/start noise, and runs a behavioural
// FIFO + adder driven by the DUT strobes to check the drained partial sums.

module tb_fifo_seq_ctrl;

  localparam int FS = 16;
  localparam int AW = 5;
  localparam int PW = 8;

  localparam logic [10:0] BRclr  = 11'h400;
  localparam logic [10:0] BWclr  = 11'h200;
  localparam logic [10:0] BRen   = 11'h100;
  localparam logic [10:0] BRinc  = 11'h080;
  localparam logic [10:0] BWen   = 11'h040;
  localparam logic [10:0] BWinc  = 11'h020;
  localparam logic [10:0] BAcc   = 11'h010;
  localparam logic [10:0] BOut   = 11'h008;
  localparam logic [10:0] BFirst = 11'h004;
  localparam logic [10:0] BBusy  = 11'h002;
  localparam logic [10:0] BDone  = 11'h001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] row_len;
  logic [PW-1:0] num_pass;
  logic          stall;
  logic          rd_clr, wr_clr, rd_en, rd_inc, wr_en, wr_inc;
  logic          acc_vld, out_vld, first_pass, busy, done;
  logic [PW-1:0] pass_idx;
`ifdef FIFO_SEQ_CTRL_ERR_EN
  logic          err;
`endif
  logic [10:0]   obs;

  assign obs = {rd_clr, wr_clr, rd_en, rd_inc, wr_en, wr_inc, acc_vld, out_vld, first_pass,
                busy, done};

  always #5 clk = ~clk;

  fifo_seq_ctrl #(
    .FIFO_SIZE (FS),
    .ADDR_WIDTH(AW),
    .PASS_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_len   (row_len),
    .num_pass  (num_pass),
    .stall     (stall),
    .rd_clr    (rd_clr),
    .wr_clr    (wr_clr),
    .rd_en     (rd_en),
    .rd_inc    (rd_inc),
    .wr_en     (wr_en),
    .wr_inc    (wr_inc),
    .acc_vld   (acc_vld),
    .out_vld   (out_vld),
    .first_pass(first_pass),
    .pass_idx  (pass_idx),
    .busy      (busy),
`ifdef FIFO_SEQ_CTRL_ERR_EN
    .err       (err),
`endif
    .done      (done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural FIFO + adder, driven by strobes captured mid-cycle.
  int   mem [32];
  int   xin [32];
  int   rd_ptr = 0;
  int   wr_ptr = 0;
  int   rdata  = 0;
  logic s_rclr = 0, s_wclr = 0, s_ren = 0, s_rinc = 0, s_wen = 0, s_winc = 0, s_first = 0;

  always @(negedge clk) begin
    s_rclr  = rd_clr;
    s_wclr  = wr_clr;
    s_ren   = rd_en;
    s_rinc  = rd_inc;
    s_wen   = wr_en;
    s_winc  = wr_inc;
    s_first = first_pass;
    if (rd_en && wr_en) check("ptr_collide", 32'(rd_ptr == wr_ptr), 32'd0);
  end

  always @(posedge clk) begin
    int wd;
    int ra;
    int wa;
    ra = rd_ptr % 32;
    wa = wr_ptr % 32;
    wd = s_first ? xin[wa] : rdata + xin[wa];
    if (s_ren) rdata = mem[ra];
    if (s_wen) mem[wa] = wd;
    if (s_rclr) rd_ptr = 0;
    else if (s_rinc) rd_ptr++;
    if (s_wclr) wr_ptr = 0;
    else if (s_winc) wr_ptr++;
  end

  // Expected trace, one entry per cycle starting with the CLR cycle.
  logic [10:0] exp_q [$];
  int          pidx_q[$];
  bit          gap_q [$];
  int          gap_len[$];

  function automatic void push(input logic [10:0] v, input int p, input bit g);
    exp_q.push_back(v);
    pidx_q.push_back(p);
    gap_q.push_back(g);
  endfunction

  function automatic void build(input int l, input int ne);
    logic [10:0] v;
    exp_q.delete();
    pidx_q.delete();
    gap_q.delete();
    push(BRclr | BWclr | BBusy, 0, 1'b0);
    for (int i = 0; i < l; i++) push(BWen | BWinc | BFirst | BBusy, 0, 1'b0);
    for (int p = 1; p <= ne; p++) begin
      for (int g = 0; g < gap_len[p-1]; g++) push(BRclr | BWclr | BBusy, p, 1'b1);
      for (int k = 0; k <= l; k++) begin
        v = BBusy;
        if (k < l) v = v | BRen | BRinc;
        if (k >= 1) v = v | ((p < ne) ? (BWen | BWinc | BAcc) : BOut);
        push(v, p, 1'b0);
      end
    end
    push(BDone | BBusy, ne, 1'b0);
  endfunction

  function automatic void set_gaps(input int ne, input bit rnd);
    gap_len.delete();
    for (int p = 0; p < ne; p++) gap_len.push_back(rnd ? int'($urandom_range(1, 3)) : 1);
  endfunction

  task automatic run(input int l, input int n, input bit noise, input int abort_at);
    int ne;
    int didx;
    int nwr;
    int nrd;
    bit overlap;
    ne      = (n == 0) ? 1 : n;
    didx    = 0;
    nwr     = 0;
    nrd     = 0;
    overlap = 1'b0;
    build(l, ne);
    for (int i = 0; i < 32; i++) xin[i] = int'($urandom_range(0, 1000));
    @(negedge clk);
    check("pre_idle", 32'(obs), 32'd0);
    start    = 1'b1;
    row_len  = AW'(l);
    num_pass = PW'(n);
    stall    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check("abort_outs", {13'd0, obs, pass_idx}, 32'd0);
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      overlap = overlap | start;
      check($sformatf("strobes[%0d]", t), 32'(obs), 32'(exp_q[t]));
      check($sformatf("pass_idx[%0d]", t), 32'(pass_idx), 32'(pidx_q[t]));
      if ((exp_q[t] & BOut) != 0) begin
        check($sformatf("drain_data[%0d]", didx), rdata, ne * xin[didx]);
        didx++;
      end
      nwr += int'(wr_en);
      nrd += int'(rd_en);
      if (gap_q[t] && (t + 1 < exp_q.size()) && gap_q[t+1]) stall = 1'b1;
      else if (gap_q[t]) stall = 1'b0;
      else stall = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    check("idle_after", 32'(obs), 32'd0);
    check("wr_count", nwr, ne * l);
    check("rd_count", nrd, ne * l);
    check("out_count", didx, l);
`ifdef FIFO_SEQ_CTRL_ERR_EN
    check("err_overlap", 32'(err), 32'(overlap));
`endif
  endtask

  task automatic illegal(input int l);
    @(negedge clk);
    start    = 1'b1;
    row_len  = AW'(l);
    num_pass = PW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("illegal_%0d", l), 32'(obs), 32'd0);
      @(negedge clk);
    end
`ifdef FIFO_SEQ_CTRL_ERR_EN
    check("err_illegal", 32'(err), 32'd1);
`endif
  endtask

  initial begin
    int l;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    row_len  = '0;
    num_pass = '0;
    repeat (3) @(negedge clk);
    check("reset_strobes", 32'(obs), 32'd0);
    check("reset_pass_idx", 32'(pass_idx), 32'd0);
`ifdef FIFO_SEQ_CTRL_ERR_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    rst_n = 1'b1;

    set_gaps(3, 1'b0);
    run(4, 3, 1'b0, -1);              // basic run
    set_gaps(1, 1'b0);
    run(2, 0, 1'b0, -1);              // single pass
    gap_len.delete();
    gap_len.push_back(5);
    gap_len.push_back(1);
    run(4, 2, 1'b0, -1);              // stalled first gap
    illegal(0);
    illegal(17);
    set_gaps(3, 1'b0);
    run(4, 3, 1'b0, 8);               // reset during first ACC
    set_gaps(3, 1'b0);
    run(4, 3, 1'b0, -1);              // clean rerun after reset
    set_gaps(2, 1'b0);
    run(16, 2, 1'b0, -1);             // full depth
    for (int r = 0; r < 12; r++) begin
      l = int'($urandom_range(1, FS));
      n = int'($urandom_range(0, 5));
      set_gaps((n == 0) ? 1 : n, 1'b1);
      run(l, n, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
